// File: rtl/cpu_uart_sched.sv
// rtl/cpu_uart_sched.sv - UART command scheduler for the 8-bit core (optional arg timeout: CMD_TIMEOUT_EN)
module cpu_uart_sched #(
    parameter int TIMEOUT_CYCLES = 1_000_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] rx_data,
    input  logic       rx_ready,
    input  logic       tx_busy,
    output logic       tx_start,
    output logic [7:0] tx_data,
    output logic       cpu_en,
    input  logic [7:0] pc,
    input  logic [7:0] alu_res,
    output logic       dbg_we,
    output logic [1:0] dbg_addr,
    output logic [7:0] dbg_wdata,
    input  logic [7:0] dbg_rdata,
    output logic       running,
    output logic       rx_overrun
);

    typedef enum logic [2:0] {IDLE, ARG1, ARG2, EXEC_WR, STEP, SEND, TXWAIT} state_t;

    // Where the response byte comes from when it is loaded in SEND.
    localparam logic [1:0] SRC_HELD  = 2'd0;
    localparam logic [1:0] SRC_RDATA = 2'd1;
    localparam logic [1:0] SRC_ALU   = 2'd2;

    state_t     state, state_d;
    logic [7:0] cmd, cmd_d;
    logic [8:0] step_cnt, step_cnt_d;
    logic [1:0] resp_src, resp_src_d;
    logic       tx_start_d, dbg_we_d, running_d, rx_overrun_d;
    logic [7:0] tx_data_d, dbg_wdata_d;
    logic [1:0] dbg_addr_d;

`ifdef CMD_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    logic [TW-1:0] tmo_cnt, tmo_cnt_d;
`endif

    assign cpu_en = (running || (state == STEP)) && !dbg_we;

    always_comb begin
        state_d      = state;
        cmd_d        = cmd;
        step_cnt_d   = step_cnt;
        resp_src_d   = resp_src;
        tx_start_d   = 1'b0;
        tx_data_d    = tx_data;
        dbg_we_d     = 1'b0;
        dbg_addr_d   = dbg_addr;
        dbg_wdata_d  = dbg_wdata;
        running_d    = running;
        rx_overrun_d = rx_overrun;

        case (state)
            IDLE: begin
                if (rx_ready) begin
                    cmd_d      = rx_data;
                    resp_src_d = SRC_HELD;
                    state_d    = SEND;
                    case (rx_data)
                        8'h01, 8'h02, 8'h03: state_d = ARG1;
                        8'h04: begin running_d = 1'b1; tx_data_d = 8'hAA; end
                        8'h05: begin running_d = 1'b0; tx_data_d = 8'hAA; end
                        8'h06: tx_data_d = pc;
                        8'h07: begin rx_overrun_d = 1'b0; tx_data_d = 8'hAA; end
                        default: tx_data_d = 8'hEE;
                    endcase
                end
            end
            ARG1: begin
                if (rx_ready) begin
                    case (cmd)
                        8'h01: begin
                            dbg_addr_d = rx_data[1:0];
                            state_d    = ARG2;
                        end
                        8'h02: begin
                            dbg_addr_d = rx_data[1:0];
                            resp_src_d = SRC_RDATA;
                            state_d    = SEND;
                        end
                        default: begin
                            step_cnt_d = (rx_data == 8'h00) ? 9'd256 : {1'b0, rx_data};
                            running_d  = 1'b0;
                            state_d    = STEP;
                        end
                    endcase
                end
            end
            ARG2: begin
                if (rx_ready) begin
                    dbg_wdata_d = rx_data;
                    dbg_we_d    = 1'b1;
                    tx_data_d   = 8'hAA;
                    state_d     = EXEC_WR;
                end
            end
            STEP: begin
                if (cpu_en) begin
                    step_cnt_d = step_cnt - 9'd1;
                    if (step_cnt == 9'd1) begin
                        resp_src_d = SRC_ALU;
                        state_d    = SEND;
                    end
                end
            end
            // EXEC_WR doubles as the first SEND cycle so the ack follows the write strobe directly.
            EXEC_WR, SEND: begin
                if (resp_src == SRC_RDATA) tx_data_d = dbg_rdata;
                else if (resp_src == SRC_ALU) tx_data_d = alu_res;
                resp_src_d = SRC_HELD;
                if (!tx_busy) begin
                    tx_start_d = 1'b1;
                    state_d    = TXWAIT;
                end else begin
                    state_d = SEND;
                end
            end
            TXWAIT: begin
                if (tx_busy) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        if (rx_ready && !(state inside {IDLE, ARG1, ARG2})) rx_overrun_d = 1'b1;

`ifdef CMD_TIMEOUT_EN
        tmo_cnt_d = '0;
        if ((state == ARG1 || state == ARG2) && !rx_ready) begin
            if (tmo_cnt == TW'(TIMEOUT_CYCLES - 1)) begin
                state_d    = SEND;
                tx_data_d  = 8'hEE;
                resp_src_d = SRC_HELD;
            end else begin
                tmo_cnt_d = tmo_cnt + 1'b1;
            end
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state      <= IDLE;
            cmd        <= 8'h00;
            step_cnt   <= 9'd0;
            resp_src   <= SRC_HELD;
            tx_start   <= 1'b0;
            tx_data    <= 8'h00;
            dbg_we     <= 1'b0;
            dbg_addr   <= 2'd0;
            dbg_wdata  <= 8'h00;
            running    <= 1'b0;
            rx_overrun <= 1'b0;
`ifdef CMD_TIMEOUT_EN
            tmo_cnt    <= '0;
`endif
        end else begin
            state      <= state_d;
            cmd        <= cmd_d;
            step_cnt   <= step_cnt_d;
            resp_src   <= resp_src_d;
            tx_start   <= tx_start_d;
            tx_data    <= tx_data_d;
            dbg_we     <= dbg_we_d;
            dbg_addr   <= dbg_addr_d;
            dbg_wdata  <= dbg_wdata_d;
            running    <= running_d;
            rx_overrun <= rx_overrun_d;
`ifdef CMD_TIMEOUT_EN
            tmo_cnt    <= tmo_cnt_d;
`endif
        end
    end

endmodule

// File: tb/tb_cpu_uart_sched.sv
// tb/tb_cpu_uart_sched.sv - self-checking bench for cpu_uart_sched
module tb_cpu_uart_sched;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [7:0] rx_data = 8'h00;
    logic       rx_ready = 1'b0;
    logic       tx_busy = 1'b0;
    logic       tx_start;
    logic [7:0] tx_data;
    logic       cpu_en;
    logic [7:0] pc = 8'h00;
    logic [7:0] alu_res;
    logic       dbg_we;
    logic [1:0] dbg_addr;
    logic [7:0] dbg_wdata;
    logic [7:0] dbg_rdata;
    logic       running;
    logic       rx_overrun;

    cpu_uart_sched dut (
        .clk(clk), .rst(rst), .rx_data(rx_data), .rx_ready(rx_ready),
        .tx_busy(tx_busy), .tx_start(tx_start), .tx_data(tx_data),
        .cpu_en(cpu_en), .pc(pc), .alu_res(alu_res), .dbg_we(dbg_we),
        .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata), .dbg_rdata(dbg_rdata),
        .running(running), .rx_overrun(rx_overrun)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_bad = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Environment: regfile, transmitter and an ALU stand-in reporting the last cpu_en run length.
    logic [7:0] env_regs [4] = '{8'h00, 8'h00, 8'h00, 8'h00};
    assign dbg_rdata = env_regs[dbg_addr];
    always @(posedge clk) if (dbg_we) env_regs[dbg_addr] <= dbg_wdata;

    logic [7:0] resp_q [$];
    int  tx_cnt = 0, tx_cyc = 0, busy_cnt = 0;
    int  we_cnt = 0, we_cyc = 0, cur_len = 0, last_len = 0;
    logic [1:0] we_addr;
    logic [7:0] we_data;
    logic we_cpu_en, prev_start = 1'b0, dbl = 1'b0, force_busy = 1'b0;
    assign alu_res = last_len[7:0];

    always @(negedge clk) begin
        if (tx_start) begin
            resp_q.push_back(tx_data);
            tx_cnt   = tx_cnt + 1;
            tx_cyc   = cyc;
            busy_cnt = 3;
            if (prev_start) dbl = 1'b1;
        end else if (busy_cnt > 0) begin
            busy_cnt = busy_cnt - 1;
        end
        prev_start = tx_start;
        if (dbg_we) begin
            we_cnt = we_cnt + 1; we_cyc = cyc;
            we_addr = dbg_addr; we_data = dbg_wdata; we_cpu_en = cpu_en;
        end
        if (cpu_en) cur_len = cur_len + 1;
        else if (cur_len != 0) begin last_len = cur_len; cur_len = 0; end
        tx_busy = force_busy || (busy_cnt > 0);
    end

    typedef struct {
        logic [7:0] b0, b1, b2;
        int         n;
        logic [7:0] pcv;
        logic [7:0] exp;
        int         lat;
        logic       run;
    } vec_t;

    vec_t tbl [14];
    logic [7:0] model_regs [4] = '{8'h00, 8'h00, 8'h00, 8'h00};
    int last_rx = 0;

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec = n_vec + 1;
        if (act !== exp) begin
            n_bad = n_bad + 1;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        rx_data = b; rx_ready = 1'b1; last_rx = cyc;
        tick();
        rx_ready = 1'b0;
    endtask

    task automatic wait_resp(output logic [7:0] r, output int lat);
        int t = 0;
        while (resp_q.size() == 0 && t < 3000) begin tick(); t++; end
        if (resp_q.size() == 0) begin
            chk("resp_timeout", 32'd0, 32'd1);
            r = 8'h00; lat = -1;
        end else begin
            r = resp_q.pop_front();
            lat = tx_cyc - last_rx;
        end
        repeat (8) tick();
    endtask

    task automatic apply(input vec_t v, input string tag);
        logic [7:0] r;
        int lat, we0;
        we0 = we_cnt;
        pc = v.pcv;
        send_byte(v.b0);
        if (v.n >= 2) send_byte(v.b1);
        if (v.n >= 3) send_byte(v.b2);
        wait_resp(r, lat);
        chk({tag, "_resp"}, r, v.exp);
        chk({tag, "_lat"}, lat, v.lat);
        chk({tag, "_running"}, running, v.run);
        if (v.b0 == 8'h01) begin
            chk({tag, "_we_count"}, we_cnt - we0, 1);
            chk({tag, "_we_addr"}, we_addr, v.b1 & 8'h03);
            chk({tag, "_we_data"}, we_data, v.b2);
            chk({tag, "_we_cpu_en"}, we_cpu_en, 0);
            chk({tag, "_we_cycle"}, we_cyc, last_rx + 1);
        end
    endtask

    initial begin
        logic [7:0] r;
        int lat, t0, k;
        vec_t v;

        tbl[0]  = '{8'h06, 8'h00, 8'h00, 1, 8'h00, 8'h00, 2, 1'b0};
        tbl[1]  = '{8'h01, 8'h02, 8'h5A, 3, 8'h00, 8'hAA, 2, 1'b0};
        tbl[2]  = '{8'h02, 8'h02, 8'h00, 2, 8'h00, 8'h5A, 2, 1'b0};
        tbl[3]  = '{8'h03, 8'h05, 8'h00, 2, 8'h00, 8'h05, 7, 1'b0};
        tbl[4]  = '{8'h04, 8'h00, 8'h00, 1, 8'h00, 8'hAA, 2, 1'b1};
        tbl[5]  = '{8'h04, 8'h00, 8'h00, 1, 8'h00, 8'hAA, 2, 1'b1};
        tbl[6]  = '{8'h05, 8'h00, 8'h00, 1, 8'h00, 8'hAA, 2, 1'b0};
        tbl[7]  = '{8'h9C, 8'h00, 8'h00, 1, 8'h00, 8'hEE, 2, 1'b0};
        tbl[8]  = '{8'h07, 8'h00, 8'h00, 1, 8'h00, 8'hAA, 2, 1'b0};
        tbl[9]  = '{8'h01, 8'hFF, 8'h33, 3, 8'h00, 8'hAA, 2, 1'b0};
        tbl[10] = '{8'h02, 8'h07, 8'h00, 2, 8'h00, 8'h33, 2, 1'b0};
        tbl[11] = '{8'h06, 8'h00, 8'h00, 1, 8'hC3, 8'hC3, 2, 1'b0};
        tbl[12] = '{8'h00, 8'h00, 8'h00, 1, 8'h00, 8'hEE, 2, 1'b0};
        tbl[13] = '{8'h03, 8'h00, 8'h00, 2, 8'h00, 8'h00, 258, 1'b0};

        // Reset held for three cycles.
        repeat (3) tick();
        chk("reset_outputs", {tx_start, tx_data, cpu_en, dbg_we, dbg_addr, dbg_wdata, running, rx_overrun}, 0);
        rst = 1'b1;
        tick();
        chk("post_reset_cpu_en", cpu_en, 0);

        for (int i = 0; i < 14; i++) begin
            apply(tbl[i], $sformatf("tbl%0d", i));
            if (tbl[i].b0 == 8'h01) model_regs[tbl[i].b1[1:0]] = tbl[i].b2;
        end

        // RUN takes effect the cycle after the byte; HALT drops cpu_en the cycle after.
        send_byte(8'h04);
        chk("run_cpu_en_next", cpu_en, 1);
        k = 0;
        repeat (20) begin tick(); if (!cpu_en) k++; end
        chk("run_cpu_en_continuous", k, 0);
        wait_resp(r, lat);
        chk("run_resp", r, 8'hAA);
        send_byte(8'h05);
        chk("halt_cpu_en_next", cpu_en, 0);
        wait_resp(r, lat);
        chk("halt_resp", r, 8'hAA);

        // Transmitter held busy: no start until it frees, then exactly one.
        force_busy = 1'b1; tick(); tick();
        t0 = tx_cnt; pc = 8'h6D;
        send_byte(8'h06);
        repeat (100) tick();
        chk("busy_no_start", tx_cnt - t0, 0);
        force_busy = 1'b0;
        wait_resp(r, lat);
        chk("busy_resp", r, 8'h6D);
        chk("busy_one_start", tx_cnt - t0, 1);

        // Byte injected while in TXWAIT is dropped and flagged.
        pc = 8'h11; t0 = tx_cnt;
        send_byte(8'h06);
        tick();
        send_byte(8'h55);
        chk("overrun_set", rx_overrun, 1);
        wait_resp(r, lat);
        chk("overrun_resp", r, 8'h11);
        repeat (50) tick();
        chk("overrun_dropped", tx_cnt - t0, 1);
        v = '{8'h07, 8'h00, 8'h00, 1, 8'h00, 8'hAA, 2, 1'b0};
        apply(v, "clr");
        chk("overrun_cleared", rx_overrun, 0);

        // Argument states wait indefinitely without the timeout feature.
        t0 = tx_cnt;
        send_byte(8'h01);
        repeat (1000) tick();
        chk("no_timeout", tx_cnt - t0, 0);
        send_byte(8'h00);
        send_byte(8'h00);
        model_regs[0] = 8'h00;
        wait_resp(r, lat);
        chk("late_write_resp", r, 8'hAA);

        // Reset mid-response discards it.
        t0 = tx_cnt; pc = 8'h77;
        send_byte(8'h06);
        rst = 1'b0;
        tick(); tick();
        chk("midreset_outputs", {tx_start, tx_data, running}, 0);
        rst = 1'b1;
        repeat (20) tick();
        chk("midreset_no_start", tx_cnt - t0, 0);
        resp_q.delete();

        // Randomized commands against the command-level model.
        for (int i = 0; i < 150; i++) begin
            v = '{8'h00, 8'h00, 8'h00, 1, 8'h00, 8'hAA, 2, 1'b0};
            v.pcv = 8'($urandom);
            case ($urandom_range(0, 5))
                0: begin
                    v.b0 = 8'h01; v.b1 = 8'($urandom); v.b2 = 8'($urandom); v.n = 3;
                    model_regs[v.b1[1:0]] = v.b2;
                end
                1: begin
                    v.b0 = 8'h02; v.b1 = 8'($urandom); v.n = 2;
                    v.exp = model_regs[v.b1[1:0]];
                end
                2: begin
                    v.b0 = 8'h03; v.b1 = 8'($urandom_range(1, 12)); v.n = 2;
                    v.exp = v.b1; v.lat = v.b1 + 2;
                end
                3: begin v.b0 = 8'h06; v.exp = v.pcv; end
                4: v.b0 = 8'h07;
                default: begin v.b0 = 8'($urandom_range(8, 255)); v.exp = 8'hEE; end
            endcase
            apply(v, $sformatf("rnd%0d", i));
        end

        chk("no_double_start", dbl, 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/cpu_uart_sched.md
# cpu_uart_sched

Host-side command scheduler between the UART byte links and the 8-bit CPU core. It parses single-byte commands from `uart_rx`, sequences the core (run, halt, single/multi-step), owns the register-file debug write port (arbitrating it against the core's write-back), and returns responses through `uart_tx` with a clean one-cycle start handshake. It sits in `cpu_top` between the `uart_rx` and `uart_tx` instances and the PC, regfile and ALU.

## Interface
- `TIMEOUT_CYCLES`, 1_000_000: argument-byte timeout in `clk` cycles. Used only when `CMD_TIMEOUT_EN` is defined.
- `clk` in 1: system clock.
- `rst` in 1: synchronous, active-low reset. Sampled on the `clk` rising edge; `rst`=0 resets the block.
- `rx_data` in 8: received byte. Valid while `rx_ready`=1.
- `rx_ready` in 1: one-cycle strobe, new byte on `rx_data`.
- `tx_busy` in 1: transmitter busy.
- `tx_start` out 1: one-cycle transmit request.
- `tx_data` out 8: byte to send. Stable from `tx_start` until `tx_busy` rises.
- `cpu_en` out 1: PC/write-back enable for the core. Low holds the PC and blocks the core's regfile write.
- `pc` in 8: current core PC.
- `alu_res` in 8: current ALU result.
- `dbg_we` out 1: debug regfile write strobe. Takes priority over the core write.
- `dbg_addr` out 2: debug regfile read/write address.
- `dbg_wdata` out 8: debug write data.
- `dbg_rdata` in 8: regfile read data at `dbg_addr` (combinational).
- `running` out 1: free-run mode active.
- `rx_overrun` out 1: sticky flag. Set when a byte is dropped; cleared by reset or command 0x07.

## Operation
- States: IDLE, ARG1, ARG2, EXEC_WR, STEP, SEND, TXWAIT.
- Commands are accepted only in IDLE. Argument bytes are accepted in ARG1 and ARG2. A byte with `rx_ready`=1 in any other state is dropped and sets `rx_overrun`.
- 0x01 WRITE: expects addr byte, then data byte. Uses `addr[1:0]`; upper bits are ignored. Issues one `dbg_we` pulse in EXEC_WR, then responds 0xAA.
- 0x02 READ: expects addr byte. Responds `dbg_rdata`, sampled the cycle after the addr byte is received.
- 0x03 STEP: expects count byte N. Drives `cpu_en`=1 for exactly N cycles; N=0 means 256. Then responds with `alu_res`, sampled in the first cycle after `cpu_en` drops. Clears `running` on entry.
- 0x04 RUN: sets `running`, responds 0xAA. RUN while already running is harmless and still responds 0xAA.
- 0x05 HALT: clears `running`, responds 0xAA.
- 0x06 PC: responds `pc`, sampled on the cycle the command is received.
- 0x07 CLR: clears `rx_overrun`, responds 0xAA.
- Any other byte: responds 0xEE (NAK). No other state changes.
- `cpu_en` = (`running` OR STEP active) AND NOT `dbg_we`. A debug write steals exactly one core cycle. The STEP count does not decrement in a stolen cycle; this cannot occur in practice, since `dbg_we` only fires in EXEC_WR.
- Responses use the SEND and TXWAIT states:
  - SEND loads `tx_data`. Once `tx_busy`=0, it pulses `tx_start` for exactly one cycle and moves to TXWAIT.
  - TXWAIT waits for `tx_busy`=1, then returns to IDLE.
  - `tx_start` is never asserted in two consecutive cycles.

## Timing
- Reset values: `tx_start`=0, `tx_data`=0x00, `cpu_en`=0, `dbg_we`=0, `dbg_addr`=0, `dbg_wdata`=0, `running`=0, `rx_overrun`=0, state IDLE, step counter 0.
- Reset asserted mid-operation aborts immediately. Any pending response is discarded and `tx_start` is not asserted.
- The command byte's `rx_ready` cycle is the edge that leaves IDLE.
- WRITE: `dbg_we` is high exactly 1 cycle, in the cycle after the data byte's `rx_ready`.
- Response latency with `tx_busy`=0:
  - READ, RUN, HALT, PC and CLR: `tx_start` 2 cycles after the final byte's `rx_ready`.
  - WRITE: `tx_start` 1 cycle after `dbg_we`.
- STEP: `cpu_en` rises the cycle after the count byte and stays high for exactly N cycles, including 256 for N=0.
- `running` takes effect on `cpu_en` the cycle after the RUN/HALT byte.
- Free-run continues during SEND/TXWAIT and the argument states.

## Configuration
- `CMD_TIMEOUT_EN` defined:
  - A cycle counter runs in ARG1 and ARG2 and restarts on each accepted byte.
  - On reaching `TIMEOUT_CYCLES`, the command aborts and responds 0xEE; state goes to SEND.
- `CMD_TIMEOUT_EN` undefined: the argument states wait indefinitely. The counter and `TIMEOUT_CYCLES` are unused and not synthesised.

## Test plan
- Reset: hold `rst`=0 for 3 cycles, release -> all outputs at reset values, `cpu_en`=0; send 0x06 with `pc`=0x00 -> exactly one `tx_start` with `tx_data`=0x00.
- Bytes 0x01, 0x02, 0x5A -> single `dbg_we` pulse with `dbg_addr`=2, `dbg_wdata`=0x5A, `cpu_en`=0 that cycle; response 0xAA. Then 0x02, 0x02 with `dbg_rdata`=0x5A -> response 0x5A.
- Bytes 0x03, 0x05 -> `cpu_en` high exactly 5 cycles, response equals `alu_res` on the cycle after. Bytes 0x03, 0x00 -> `cpu_en` high exactly 256 cycles.
- Bytes 0x04 -> `running`=1, `cpu_en` continuous, response 0xAA. Bytes 0x05 -> `cpu_en`=0 the next cycle, response 0xAA. Byte 0x9C -> response 0xEE.
- Hold `tx_busy`=1 for 100 cycles, send 0x06 -> no `tx_start` until `tx_busy` falls, then exactly one pulse. A byte injected during TXWAIT -> `rx_overrun`=1; 0x07 clears it.
- With `CMD_TIMEOUT_EN` defined and `TIMEOUT_CYCLES`=50, send 0x01 only -> response 0xEE at cycle 50 after the command. Without the macro -> no response after 1000 cycles.
